conv_result_streamer: RTL and testbench

CONV_RESULT_STREAMER -- requirements
Module: conv_result_streamer

---
 rtl/conv_stream_pkg.sv | 17 +
 rtl/requant_sat.sv | 39 +++
 rtl/conv_result_streamer.sv | 155 +++++++++++++++
 tb/tb_conv_result_streamer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_stream_pkg.sv
// Shared definitions for the convolution result streamer.
//   state_t : streamer FSM states (IDLE, STREAM, DONE)
//   cnt_w   : counter/index width helper, never narrower than one bit so a
//             dimension of size 1 still yields a legal vector.
package conv_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/requant_sat.sv
// Requantizer: arithmetic right shift by SHIFT, optional ReLU, then
// saturation of a 2*BITWIDTH signed value into a BITWIDTH signed value.
// Ports:
//   in_i  : signed 2*BITWIDTH-bit accumulator element
//   out_o : signed BITWIDTH-bit requantized element
// Build option: define CONV_STREAM_RELU_EN to clamp negative values to zero
// before saturation.
module requant_sat #(
  parameter int BITWIDTH = 8,
  parameter int SHIFT    = 0
) (
  input  logic signed [2*BITWIDTH-1:0] in_i,
  output logic signed [BITWIDTH-1:0]   out_o
);

  localparam int EW = 2 * BITWIDTH;
  // Saturation bounds expressed at the wide width for a signed compare.
  localparam logic signed [EW-1:0] MAXV = {{(BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = {{(BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};

  logic signed [EW-1:0] shifted;
  logic signed [EW-1:0] clipped;

  always_comb begin
    shifted = in_i >>> SHIFT;
`ifdef CONV_STREAM_RELU_EN
    clipped = shifted[EW-1] ? '0 : shifted;
`else
    clipped = shifted;
`endif
    out_o = clipped[BITWIDTH-1:0];
    if (clipped > MAXV) begin
      out_o = MAXV[BITWIDTH-1:0];
    end else if (clipped < MINV) begin
      out_o = MINV[BITWIDTH-1:0];
    end
  end

endmodule

// File: rtl/conv_result_streamer.sv
// Captures a flat convolution result bus on start and streams its elements,
// requantized to BITWIDTH bits, over a valid/ready interface in ascending
// element order (column fastest, then row, then channel).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : one-cycle capture request (honoured only in IDLE)
//   result       : flat bus, element e at [e*2*BITWIDTH +: 2*BITWIDTH]
//   busy         : high in STREAM and DONE
//   out_valid/out_ready/out_data/out_channel/out_last : output stream
//   done         : one-cycle pulse after the final transfer
//   dbg_state_o  : current FSM state for observation
// Build option: CONV_STREAM_RELU_EN (see requant_sat).
//
// Handshake: a transfer happens on a rising edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_data, out_channel
// and out_last hold until that transfer; out_valid never drops without one
// (except on reset).
module conv_result_streamer
  import conv_stream_pkg::*;
#(
  parameter int BITWIDTH    = 8,
  parameter int OUTWIDTH    = 28,
  parameter int OUTHEIGHT   = 28,
  parameter int FILTERBATCH = 6,
  parameter int SHIFT       = 0
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                start,
  input  logic [2*BITWIDTH*FILTERBATCH*OUTHEIGHT*OUTWIDTH-1:0] result,
  output logic                                                busy,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [BITWIDTH-1:0]                                 out_data,
  output logic [cnt_w(FILTERBATCH)-1:0]                       out_channel,
  output logic                                                out_last,
  output logic                                                done,
  output state_t                                              dbg_state_o
);

  localparam int EW  = 2 * BITWIDTH;
  localparam int N   = FILTERBATCH * OUTHEIGHT * OUTWIDTH;
  localparam int RBW = EW * N;
  localparam int CHW = cnt_w(FILTERBATCH);
  localparam int RW  = cnt_w(OUTHEIGHT);
  localparam int CW  = cnt_w(OUTWIDTH);
  localparam int EIW = cnt_w(N);

  state_t           state_q;
  logic [RBW-1:0]   buf_q;
  logic [CHW-1:0]   ch_q;
  logic [RW-1:0]    r_q;
  logic [CW-1:0]    c_q;
  logic [EIW-1:0]   e_q;      // flat index of the element currently on out_data

  logic [EIW-1:0]   nxt_e;
  logic [EW-1:0]    rq_src;
  logic [BITWIDTH-1:0] rq_data;
  logic             xfer;

  assign nxt_e       = EIW'(e_q + 1'b1);
  assign xfer        = out_valid && out_ready;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

  // In IDLE the first element comes straight off the input bus so it can be
  // presented the cycle after start; afterwards it comes from the buffer.
  always_comb begin
    rq_src = result[EW-1:0];
    if (state_q != IDLE) begin
      rq_src = buf_q[EW*int'(nxt_e) +: EW];
    end
  end

  requant_sat #(
    .BITWIDTH(BITWIDTH),
    .SHIFT   (SHIFT)
  ) u_requant (
    .in_i (rq_src),
    .out_o(rq_data)
  );

  // The buffer needs no reset: it is only read after a fresh capture.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      buf_q <= result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= '0;
      out_last    <= 1'b0;
      done        <= 1'b0;
      ch_q        <= '0;
      r_q         <= '0;
      c_q         <= '0;
      e_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ch_q        <= '0;
            r_q         <= '0;
            c_q         <= '0;
            e_q         <= '0;
            out_valid   <= 1'b1;
            out_data    <= rq_data;
            out_channel <= '0;
            out_last    <= (N == 1);
            state_q     <= STREAM;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              done      <= 1'b1;
              state_q   <= DONE;
            end else begin
              e_q      <= nxt_e;
              out_data <= rq_data;
              out_last <= (int'(nxt_e) == N - 1);
              if (c_q == CW'(OUTWIDTH - 1)) begin
                c_q <= '0;
                if (r_q == RW'(OUTHEIGHT - 1)) begin
                  r_q         <= '0;
                  ch_q        <= CHW'(ch_q + 1'b1);
                  out_channel <= CHW'(ch_q + 1'b1);
                end else begin
                  r_q <= RW'(r_q + 1'b1);
                end
              end else begin
                c_q <= CW'(c_q + 1'b1);
              end
            end
          end
        end
        DONE: begin
          done        <= 1'b0;
          out_channel <= '0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_result_streamer.sv
module tb_conv_result_streamer;
  import conv_stream_pkg::*;

  localparam int BW  = 8;
  localparam int N   = 8;
  localparam int EW  = 16;
  localparam int RBW = EW * N;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, start, out_ready;
  logic [RBW-1:0] result;
  logic           busy, out_valid, out_last, done;
  logic [BW-1:0]  out_data;
  logic [0:0]     out_channel;
  state_t         dbg_state;

  // second instance: SHIFT=2, two elements in one channel
  logic           start2;
  logic [31:0]    result2;
  logic           busy2, out_valid2, out_last2, done2;
  logic [BW-1:0]  out_data2;
  logic [0:0]     out_channel2;
  state_t         dbg_state2;

  conv_result_streamer #(
    .BITWIDTH(8), .OUTWIDTH(2), .OUTHEIGHT(2), .FILTERBATCH(2), .SHIFT(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .result(result), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_channel(out_channel), .out_last(out_last), .done(done),
    .dbg_state_o(dbg_state)
  );

  conv_result_streamer #(
    .BITWIDTH(8), .OUTWIDTH(2), .OUTHEIGHT(1), .FILTERBATCH(1), .SHIFT(2)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .result(result2), .busy(busy2),
    .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2),
    .out_channel(out_channel2), .out_last(out_last2), .done(done2),
    .dbg_state_o(dbg_state2)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [9:0] exp_q[$];   // {last, channel, data}

  logic [15:0] elems [8];
  logic [15:0] alt_elems [8];
  logic [7:0]  exp_data [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [RBW-1:0] pack(input logic [15:0] a [8]);
    logic [RBW-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = a[i];
    return r;
  endfunction

  task automatic push_expected();
    exp_q.delete();
    for (int i = 0; i < 8; i++)
      exp_q.push_back({(i == 7) ? 1'b1 : 1'b0, (i >= 4) ? 1'b1 : 1'b0, exp_data[i]});
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
    chk({tag, "_channel"}, 32'(out_channel), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // ---------------- driver ----------------
  // mode 0: out_ready always 1; mode 1: out_ready 1,0,0,1 repeating.
  // poke: pulse start and change result while element 3 is presented.
  // rst_at >= 0: assert rst while element rst_at is presented.
  task automatic run_stream(input int mode, input bit poke, input int rst_at);
    int  got = 0;
    int  cyc = 0;
    bit  poked = 0;
    bit  aborted = 0;
    logic [3:0] pat;
    pat = 4'b1001;
    result = pack(elems);
    push_expected();
    @(negedge clk);
    start = 1'b1;
    while (got < 8) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc > 100) break;
      out_ready = (mode == 0) ? 1'b1 : pat[3 - (cyc % 4)];
      if (cyc == 0) begin
        chk("valid_after_start", 32'(out_valid), 32'd1);
        chk("busy_in_stream", 32'(busy), 32'd1);
      end
      cyc++;
      if (rst_at >= 0 && got == rst_at && out_valid) begin
        rst = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (poke && got == 3 && !poked) begin
        start  = 1'b1;
        result = pack(alt_elems);
        poked  = 1'b1;
      end
      if (out_valid) begin
        chk("data", 32'(out_data), 32'(exp_q[0][7:0]));
        chk("channel", 32'(out_channel), 32'(exp_q[0][8]));
        chk("last", 32'(out_last), 32'(exp_q[0][9]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          got++;
        end
      end
    end
    chk("stream_count", 32'(got), (rst_at >= 0) ? 32'(rst_at) : 32'd8);
    if (!aborted) begin
      @(negedge clk);
      chk("valid_low_after_last", 32'(out_valid), 32'd0);
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_in_done", 32'(busy), 32'd1);
      @(negedge clk);
      chk("done_cleared", 32'(done), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    elems = '{16'h0005, 16'hFFFD, 16'h012C, 16'hFED4,
              16'h007F, 16'h0080, 16'hFF80, 16'h0000};
    alt_elems = '{16'h0011, 16'h0022, 16'h0033, 16'h0044,
                  16'h0055, 16'h0066, 16'h0077, 16'h0001};
`ifdef CONV_STREAM_RELU_EN
    exp_data = '{8'h05, 8'h00, 8'h7F, 8'h00, 8'h7F, 8'h7F, 8'h00, 8'h00};
`else
    exp_data = '{8'h05, 8'hFD, 8'h7F, 8'h80, 8'h7F, 8'h7F, 8'h80, 8'h00};
`endif
    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    out_ready = 1'b0;
    result = pack(elems);
    result2 = {16'hFFF0, 16'h01FF};
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;

    // full-rate stream
    run_stream(0, 1'b0, -1);
    // back-pressure 1,0,0,1
    run_stream(1, 1'b0, -1);
    // start ignored mid-stream and result changed after capture
    run_stream(0, 1'b1, -1);
    result = pack(elems);

    // reset mid-stream at element 5, then restart from element 0
    run_stream(0, 1'b0, 5);
    @(negedge clk);
    chk_idle_outputs("midrst");
    rst = 1'b0;
    run_stream(0, 1'b0, -1);

    // SHIFT=2 instance: 511 -> 127, -16 -> -4
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("shift_valid0", 32'(out_valid2), 32'd1);
    chk("shift_511", 32'(out_data2), 32'h7F);
    chk("shift_last0", 32'(out_last2), 32'd0);
    @(negedge clk);
`ifdef CONV_STREAM_RELU_EN
    chk("shift_neg16", 32'(out_data2), 32'h00);
`else
    chk("shift_neg16", 32'(out_data2), 32'hFC);
`endif
    chk("shift_last1", 32'(out_last2), 32'd1);
    @(negedge clk);
    chk("shift_valid_end", 32'(out_valid2), 32'd0);
    chk("shift_done", 32'(done2), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
